mp_icache_ctrl: RTL and testbench

//  Direct-mapped refill/lookup controller for the instruction cache data array (1R1W word SRAM, 1-cycle registered read).

---
 rtl/mp_icache_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mp_icache_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_icache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mp_icache_ctrl                                                |
// | Purpose  : Direct-mapped instruction cache refill/lookup controller.     |
// |            Owns the tag and valid arrays and drives the 1R1W data array  |
// |            (1-cycle registered read). A miss fetches the whole line over |
// |            the memory bus, writes it into the array, then replays the    |
// |            lookup so that the next cycle hits.                           |
// | Ports    : sys_clk/sys_rst   clock, synchronous active-high reset        |
// |            icache_*          fetch-side request / response handshake     |
// |            arr_*             data-array read and write ports             |
// |            mem_*             line-refill memory bus                      |
// |            perf_hit/miss     event counters (ICACHE_PERF_EN only)        |
// | Options  : ICACHE_PERF_EN   adds 32-bit hit/miss counters and ports      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mp_icache_ctrl #(
    parameter int INDEX_BITS = 6,
    parameter int OFS_BITS   = 3
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic                           icache_ack,
    input  logic [29:0]                    icache_addr,
    output logic                           icache_rdy,
    output logic                           icache_vld,
    input  logic                           icache_flush,
    output logic                           arr_rd_en,
    output logic [INDEX_BITS+OFS_BITS-1:0] arr_rd_addr,
    output logic                           arr_wr_en,
    output logic [INDEX_BITS+OFS_BITS-1:0] arr_wr_addr,
    output logic [31:0]                    arr_wr_data,
    output logic                           mem_req,
    output logic [29:0]                    mem_addr,
    input  logic                           mem_gnt,
    input  logic                           mem_rvld,
    input  logic [31:0]                    mem_rdata
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]                    perf_hit,
    output logic [31:0]                    perf_miss
`endif
);

    localparam int c_TAG_BITS = 30 - INDEX_BITS - OFS_BITS;
    localparam int c_LINES    = 1 << INDEX_BITS;
    localparam int c_AW       = INDEX_BITS + OFS_BITS;

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_REQ    = 2'd1;
    localparam logic [1:0] c_S_FILL   = 2'd2;
    localparam logic [1:0] c_S_REPLAY = 2'd3;

    localparam logic [OFS_BITS-1:0] c_LAST_BEAT = '1;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [29:0]           r_la;
    logic                  r_pend;
    logic                  r_flush_pend;
    logic [OFS_BITS-1:0]   r_cnt;
    logic [c_LINES-1:0]    r_valid;
    logic [c_TAG_BITS-1:0] r_tag [c_LINES];

    logic [INDEX_BITS-1:0] w_idx;
    logic [c_TAG_BITS-1:0] w_la_tag;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_accept;
    logic                  w_beat;
    logic                  w_last_beat;

    assign w_idx       = r_la[OFS_BITS +: INDEX_BITS];
    assign w_la_tag    = r_la[29 -: c_TAG_BITS];
    // r_pend is only ever set while IDLE, so a lookup can only hit there.
    assign w_hit       = r_pend & r_valid[w_idx] & (r_tag[w_idx] == w_la_tag);
    assign w_miss      = (r_state == c_S_IDLE) & r_pend & ~w_hit;
    assign icache_rdy  = (r_state == c_S_IDLE) & ~(r_pend & ~w_hit);
    assign w_accept    = icache_ack & icache_rdy;
    assign w_beat      = (r_state == c_S_FILL) & mem_rvld;
    assign w_last_beat = w_beat & (r_cnt == c_LAST_BEAT);

    assign icache_vld  = w_hit;
    assign arr_wr_en   = w_beat;
    assign arr_wr_addr = {w_idx, r_cnt};
    assign arr_wr_data = mem_rdata;
    assign mem_addr    = {r_la[29:OFS_BITS], {OFS_BITS{1'b0}}};

    always_comb begin
        w_state_nxt = r_state;
        arr_rd_en   = 1'b0;
        arr_rd_addr = icache_addr[c_AW-1:0];
        mem_req     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                arr_rd_en = w_accept;
                if (w_miss) begin
                    w_state_nxt = c_S_REQ;
                end
            end
            c_S_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    w_state_nxt = c_S_FILL;
                end
            end
            c_S_FILL: begin
                if (w_last_beat) begin
                    w_state_nxt = c_S_REPLAY;
                end
            end
            c_S_REPLAY: begin
                // Re-read the missed word so it is on the array output in
                // the following IDLE cycle, where the lookup now hits.
                arr_rd_en   = 1'b1;
                arr_rd_addr = r_la[c_AW-1:0];
                w_state_nxt = c_S_IDLE;
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= c_S_IDLE;
            r_la         <= '0;
            r_pend       <= 1'b0;
            r_flush_pend <= 1'b0;
            r_cnt        <= '0;
            r_valid      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_S_IDLE: begin
                    if (w_miss) begin
                        // The pending lookup is parked during the refill and
                        // re-armed on the way out of REPLAY.
                        r_pend         <= 1'b0;
                        r_valid[w_idx] <= 1'b0;
                    end else if (w_accept) begin
                        r_la   <= icache_addr;
                        r_pend <= 1'b1;
                    end else if (w_hit) begin
                        r_pend <= 1'b0;
                    end
                    // Whole-vector clear overrides any per-line update above.
                    if (icache_flush) begin
                        r_valid <= '0;
                    end
                end
                c_S_REQ: begin
                    if (mem_gnt) begin
                        r_cnt <= '0;
                    end
                end
                c_S_FILL: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last_beat) begin
                            r_valid[w_idx] <= 1'b1;
                        end
                    end
                end
                c_S_REPLAY: begin
                    r_pend       <= 1'b1;
                    r_flush_pend <= 1'b0;
                    // A flush seen during the refill invalidates the freshly
                    // filled line too, so the replayed lookup refetches.
                    if (r_flush_pend | icache_flush) begin
                        r_valid <= '0;
                    end
                end
                default: ;
            endcase
            if (icache_flush && (r_state == c_S_REQ || r_state == c_S_FILL)) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: a tag is only consulted behind its valid bit.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && w_last_beat) begin
            r_tag[w_idx] <= w_la_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_perf_hit;
    logic [31:0] r_perf_miss;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_perf_hit  <= '0;
            r_perf_miss <= '0;
        end else begin
            if (w_hit) begin
                r_perf_hit <= r_perf_hit + 32'd1;
            end
            if (w_miss) begin
                r_perf_miss <= r_perf_miss + 32'd1;
            end
        end
    end

    assign perf_hit  = r_perf_hit;
    assign perf_miss = r_perf_miss;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mp_icache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mp_icache_ctrl                                             |
// | Purpose  : Self-checking bench for mp_icache_ctrl. Holds a line-level    |
// |            cache model (valid/tag per index), a data-array model and a   |
// |            backing-memory function; checks handshakes, array traffic,    |
// |            refill sequencing, flush and reset behaviour.                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mp_icache_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        icache_ack;
    logic [29:0] icache_addr;
    logic        icache_rdy;
    logic        icache_vld;
    logic        icache_flush;
    logic        arr_rd_en;
    logic [8:0]  arr_rd_addr;
    logic        arr_wr_en;
    logic [8:0]  arr_wr_addr;
    logic [31:0] arr_wr_data;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvld;
    logic [31:0] mem_rdata;
`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hit;
    logic [31:0] perf_miss;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int ref_hits   = 0;
    int ref_misses = 0;

    bit [63:0]   ref_valid;
    logic [20:0] ref_tag [64];

    logic [31:0] r_sram [512];
    logic [31:0] r_sram_q;

    always #5 sys_clk = ~sys_clk;

    mp_icache_ctrl dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .icache_ack   (icache_ack),
        .icache_addr  (icache_addr),
        .icache_rdy   (icache_rdy),
        .icache_vld   (icache_vld),
        .icache_flush (icache_flush),
        .arr_rd_en    (arr_rd_en),
        .arr_rd_addr  (arr_rd_addr),
        .arr_wr_en    (arr_wr_en),
        .arr_wr_addr  (arr_wr_addr),
        .arr_wr_data  (arr_wr_data),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvld     (mem_rvld),
        .mem_rdata    (mem_rdata)
`ifdef ICACHE_PERF_EN
        ,
        .perf_hit     (perf_hit),
        .perf_miss    (perf_miss)
`endif
    );

    // Data array: 1R1W, registered read.
    always_ff @(posedge sys_clk) begin
        if (arr_wr_en) r_sram[arr_wr_addr] <= arr_wr_data;
        if (arr_rd_en) r_sram_q <= r_sram[arr_rd_addr];
    end

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit ref_hit(input logic [29:0] a);
        logic [5:0] i;
        i = a[8:3];
        return ref_valid[i] && (ref_tag[i] == a[29:9]);
    endfunction

    task automatic clear_ref();
        ref_valid = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // One request through the full protocol. fl_beat: beat index carrying a
    // flush pulse on the first refill (-1 none). rst_beat: beat index carrying
    // a reset (-1 none). lk_flush: pulse flush in the first lookup cycle.
    task automatic request(input logic [29:0] a, input int fl_beat, input int rst_beat,
                           input bit lk_flush);
        logic [29:0] line;
        logic [5:0]  idx;
        bit          exp_hit;
        bit          flushed;
        int          n_g;
        line    = {a[29:3], 3'b000};
        idx     = a[8:3];
        exp_hit = ref_hit(a);
        icache_ack  = 1'b1;
        icache_addr = a;
        #1;
        chk("rdy_accept", 32'(icache_rdy), 32'd1);
        chk("rd_en_accept", 32'(arr_rd_en), 32'd1);
        chk("rd_addr_accept", 32'(arr_rd_addr), 32'(a[8:0]));
        tick();
        icache_ack = 1'b0;
        for (int t = 0; t < 3; t++) begin
            if (lk_flush && t == 0) icache_flush = 1'b1;
            #1;
            chk("vld_lookup", 32'(icache_vld), 32'(exp_hit));
            if (exp_hit) begin
                ref_hits++;
                chk("data_hit", r_sram_q, mem_word(a));
                chk("rdy_hit", 32'(icache_rdy), 32'd1);
                chk("no_req_hit", 32'(mem_req), 32'd0);
                tick();
                icache_flush = 1'b0;
                if (lk_flush && t == 0) clear_ref();
                return;
            end
            chk("rdy_miss", 32'(icache_rdy), 32'd0);
            tick();
            icache_flush = 1'b0;
            if (lk_flush && t == 0) clear_ref();
            ref_misses++;
            n_g = int'($urandom_range(0, 3));
            for (int g = 0; g < n_g; g++) begin
                mem_rvld  = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
                #1;
                chk("req_wait", 32'(mem_req), 32'd1);
                chk("mem_addr", 32'(mem_addr), 32'(line));
                chk("no_wr_in_req", 32'(arr_wr_en), 32'd0);
                tick();
            end
            mem_rvld = 1'b0;
            mem_gnt  = 1'b1;
            #1;
            chk("req_gnt", 32'(mem_req), 32'd1);
            chk("mem_addr_gnt", 32'(mem_addr), 32'(line));
            tick();
            mem_gnt = 1'b0;
            flushed = 1'b0;
            for (int b = 0; b < 8; b++) begin
                n_g = int'($urandom_range(0, 2));
                for (int g = 0; g < n_g; g++) begin
                    #1;
                    chk("fill_gap_no_wr", 32'(arr_wr_en), 32'd0);
                    chk("fill_no_req", 32'(mem_req), 32'd0);
                    tick();
                end
                mem_rvld  = 1'b1;
                mem_rdata = mem_word(line | 30'(b));
                if (b == rst_beat) begin
                    sys_rst = 1'b1;
                    tick();
                    sys_rst    = 1'b0;
                    mem_rvld   = 1'b0;
                    clear_ref();
                    ref_hits   = 0;
                    ref_misses = 0;
                    return;
                end
                if (t == 0 && b == fl_beat) begin
                    icache_flush = 1'b1;
                    flushed      = 1'b1;
                end
                #1;
                chk("fill_wr_en", 32'(arr_wr_en), 32'd1);
                chk("fill_wr_addr", 32'(arr_wr_addr), 32'({idx, 3'(b)}));
                chk("fill_wr_data", arr_wr_data, mem_word(line | 30'(b)));
                tick();
                mem_rvld     = 1'b0;
                icache_flush = 1'b0;
            end
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = a[29:9];
            if (flushed) clear_ref();
            #1;
            chk("replay_rd_en", 32'(arr_rd_en), 32'd1);
            chk("replay_rd_addr", 32'(arr_rd_addr), 32'(a[8:0]));
            chk("replay_no_vld", 32'(icache_vld), 32'd0);
            chk("replay_no_rdy", 32'(icache_rdy), 32'd0);
            tick();
            exp_hit = ref_hit(a);
        end
        n_cmp++;
        n_fail++;
        $error("FAIL refill_rounds: observed no hit after 3 refills, expected a hit");
    endtask

    // Back-to-back accepts; each cycle carries the previous lookup's result.
    task automatic burst(input logic [29:0] base, input int n);
        logic [29:0] prev;
        bit          prev_hit;
        prev     = base;
        prev_hit = 1'b0;
        for (int k = 0; k < n; k++) begin
            icache_ack  = 1'b1;
            icache_addr = base + 30'(k);
            #1;
            if (k > 0) begin
                chk("burst_vld", 32'(icache_vld), 32'(prev_hit));
                if (prev_hit) begin
                    ref_hits++;
                    chk("burst_data", r_sram_q, mem_word(prev));
                end
            end
            chk("burst_rdy", 32'(icache_rdy), 32'd1);
            chk("burst_no_req", 32'(mem_req), 32'd0);
            prev     = base + 30'(k);
            prev_hit = ref_hit(prev);
            tick();
        end
        icache_ack = 1'b0;
        #1;
        chk("burst_last_vld", 32'(icache_vld), 32'(prev_hit));
        if (prev_hit) begin
            ref_hits++;
            chk("burst_last_data", r_sram_q, mem_word(prev));
        end
        tick();
    endtask

    task automatic idle_flush();
        icache_flush = 1'b1;
        #1;
        chk("flush_idle_rdy", 32'(icache_rdy), 32'd1);
        tick();
        icache_flush = 1'b0;
        clear_ref();
    endtask

    initial begin
        logic [20:0] tags [3];
        logic [5:0]  idxs [4];
        logic [29:0] a;
        int          fl;
        tags = '{21'h0, 21'h1, 21'h15};
        idxs = '{6'h20, 6'h21, 6'h3F, 6'h00};

        sys_rst      = 1'b1;
        icache_ack   = 1'b0;
        icache_addr  = '0;
        icache_flush = 1'b0;
        mem_gnt      = 1'b0;
        mem_rvld     = 1'b0;
        mem_rdata    = '0;
        clear_ref();
        repeat (3) tick();
        sys_rst = 1'b0;
        #1;
        chk("rst_rdy", 32'(icache_rdy), 32'd1);
        chk("rst_vld", 32'(icache_vld), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wr_en", 32'(arr_wr_en), 32'd0);
        chk("rst_rd_en", 32'(arr_rd_en), 32'd0);
        tick();

        // Cold miss, then streaming hits through the rest of the line.
        request(30'h100, -1, -1, 1'b0);
        burst(30'h101, 7);
`ifdef ICACHE_PERF_EN
        #1;
        chk("perf_miss_t6", perf_miss, 32'd1);
        chk("perf_hit_t6", perf_hit, 32'd8);
        tick();
`endif

        // Same index, different tag: evicts and refetches.
        request(30'h2100, -1, -1, 1'b0);
        request(30'h100, -1, -1, 1'b0);

        // Flush in IDLE, flush coincident with a hitting lookup, flush during fill.
        idle_flush();
        request(30'h100, -1, -1, 1'b0);
        request(30'h103, -1, -1, 1'b1);
        request(30'h100, -1, -1, 1'b0);
        request(30'h2100, 5, -1, 1'b0);
        request(30'h180, 7, -1, 1'b0);
        request(30'h181, -1, -1, 1'b0);

        // Reset at fill beat 4: bus abandoned, stray beats ignored, line invalid.
        request(30'h140, -1, 4, 1'b0);
        #1;
        chk("rstfill_mem_req", 32'(mem_req), 32'd0);
        chk("rstfill_rdy", 32'(icache_rdy), 32'd1);
        chk("rstfill_vld", 32'(icache_vld), 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            mem_rvld  = 1'b1;
            mem_rdata = $urandom;
            #1;
            chk("rstfill_stray_beat", 32'(arr_wr_en), 32'd0);
            tick();
        end
        mem_rvld = 1'b0;
        request(30'h140, -1, -1, 1'b0);
        request(30'h100, -1, -1, 1'b0);

        // Randomised mix over a few colliding lines.
        for (int r = 0; r < 40; r++) begin
            a  = {tags[$urandom_range(0, 2)], idxs[$urandom_range(0, 3)], 3'($urandom_range(0, 7))};
            fl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
            if ($urandom_range(0, 9) == 0) idle_flush();
            request(a, fl, -1, 1'($urandom_range(0, 9) == 0));
        end

`ifdef ICACHE_PERF_EN
        #1;
        chk("perf_hit_end", perf_hit, 32'(ref_hits));
        chk("perf_miss_end", perf_miss, 32'(ref_misses));
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
